// File: rtl/gray_burst_arbiter.sv
// Round-robin arbiter lending one shared 3-bit Gray counter to NREQ requesters for Len-step bursts.
// Define GRAY_OVF_ABORT_EN to end a burst as soon as the counter reports a wrap.
module gray_burst_arbiter #(
  parameter int NREQ  = 2,
  parameter int LEN_W = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [NREQ-1:0]       Req,
  input  logic [NREQ*LEN_W-1:0] Len,
  output logic [NREQ-1:0]       Grant,
  output logic                  Busy,
  output logic                  Done,
  output logic [2:0]            Done_id,
  output logic                  Err,
  output logic                  Gray_Reset,
  output logic                  Gray_En,
  input  logic                  Gray_Overflow
);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t             state;
  logic [2:0]         rr;
  logic [2:0]         owner;
  logic [LEN_W-1:0]   cnt;
  logic               en_q;

  logic               pick_vld;
  logic [2:0]         pick;
  logic [LEN_W-1:0]   pick_len;
  logic [3:0]         idx;
  logic [2:0]         rr_next;

  // First pending requester at or above rr, wrapping modulo NREQ.
  always_comb begin
    pick_vld = 1'b0;
    pick     = 3'd0;
    idx      = 4'd0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, rr} + 4'(k);
      if (idx >= 4'(NREQ)) idx = idx - 4'(NREQ);
      for (int i = 0; i < NREQ; i++) begin
        if (!pick_vld && idx == 4'(i) && Req[i]) begin
          pick_vld = 1'b1;
          pick     = 3'(i);
        end
      end
    end
  end

  always_comb begin
    pick_len = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick == 3'(i)) pick_len = Len[i*LEN_W +: LEN_W];
    end
  end

  assign rr_next = (owner == 3'(NREQ-1)) ? 3'd0 : owner + 3'd1;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      Grant   <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Done_id <= 3'd0;
      en_q    <= 1'b0;
      rr      <= 3'd0;
      owner   <= 3'd0;
      cnt     <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state <= CLEAR;
            Grant <= NREQ'(1) << pick;
            Busy  <= 1'b1;
            owner <= pick;
            cnt   <= pick_len;
          end
        end
        CLEAR: begin
          if (cnt != '0) begin
            state <= RUN;
            en_q  <= 1'b1;
          end else begin
            state   <= DONE;
            Done    <= 1'b1;
            Done_id <= owner;
          end
        end
        RUN: begin
          cnt <= cnt - LEN_W'(1);
`ifdef GRAY_OVF_ABORT_EN
          if (cnt == LEN_W'(1) || Gray_Overflow) begin
`else
          if (cnt == LEN_W'(1)) begin
`endif
            state   <= DONE;
            en_q    <= 1'b0;
            Done    <= 1'b1;
            Done_id <= owner;
          end
        end
        DONE: begin
          state <= IDLE;
          Grant <= '0;
          Busy  <= 1'b0;
          rr    <= rr_next;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Overflow is read live in DONE so it already includes the final enable.
  assign Err        = (state == DONE) && Gray_Overflow;
  assign Gray_Reset = Reset || (state == CLEAR);
`ifdef GRAY_OVF_ABORT_EN
  assign Gray_En    = en_q && !Reset && !Gray_Overflow;
`else
  assign Gray_En    = en_q && !Reset;
`endif

endmodule

// File: tb/tb_gray_burst_arbiter.sv
// Self-checking bench for gray_burst_arbiter with a behavioural model of the shared counter.
// Expected bursts are queued when requested and compared at each Done pulse.
module tb_gray_burst_arbiter;

  localparam int NREQ  = 2;
  localparam int LEN_W = 4;

  logic                  clk = 1'b0;
  logic                  Reset;
  logic [NREQ-1:0]       Req;
  logic [NREQ*LEN_W-1:0] Len;
  logic [NREQ-1:0]       Grant;
  logic                  Busy, Done, Err, Gray_Reset, Gray_En, Gray_Overflow;
  logic [2:0]            Done_id;

  gray_burst_arbiter #(.NREQ(NREQ), .LEN_W(LEN_W)) dut (
    .Clk(clk), .Reset(Reset), .Req(Req), .Len(Len), .Grant(Grant), .Busy(Busy),
    .Done(Done), .Done_id(Done_id), .Err(Err), .Gray_Reset(Gray_Reset),
    .Gray_En(Gray_En), .Gray_Overflow(Gray_Overflow)
  );

  always #5 clk = ~clk;

  // Shared counter: wraps on the 8th enable after clear, overflow is sticky.
  logic [2:0] gcount;
  always @(posedge clk) begin
    if (Gray_Reset) begin
      gcount        <= 3'd0;
      Gray_Overflow <= 1'b0;
    end else if (Gray_En) begin
      gcount <= gcount + 3'd1;
      if (gcount == 3'd7) Gray_Overflow <= 1'b1;
    end
  end

  typedef struct { int id; int en; int err; int gc; } exp_t;
  typedef struct { logic [1:0] req; int len0; int len1; int id; } vec_t;

  exp_t sbq[$];
  int   nvec = 0;
  int   nerr = 0;

  task automatic check(input string name, input int act, input int req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push_exp(input int id, input int len);
    exp_t e;
    e.id  = id;
    e.err = (len >= 8) ? 1 : 0;
`ifdef GRAY_OVF_ABORT_EN
    e.en  = (len > 8) ? 8 : len;
    e.gc  = 2 + ((len > 8) ? 9 : len);
`else
    e.en  = len;
    e.gc  = 2 + len;
`endif
    sbq.push_back(e);
  endtask

  // Per-cycle monitor: burst statistics plus structural invariants.
  int en_cnt = 0, gcnt = 0;
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (Gray_Reset) en_cnt = 0;
    if (Gray_En) en_cnt++;
    if (Grant == '0) gcnt = 0; else gcnt++;
    if ($countones(Grant) > 1) begin
      nerr++; $display("FAIL grant_onehot: got %b, required at most one bit", Grant);
    end
    if (Busy !== (Grant != '0)) begin
      nerr++; $display("FAIL busy: got %b, required %b", Busy, Grant != '0);
    end
    if (Gray_En && Gray_Reset && !Reset) begin
      nerr++; $display("FAIL en_and_clear: got both high, required exclusive");
    end
    if (Reset && Gray_En) begin
      nerr++; $display("FAIL en_in_reset: got 1, required 0");
    end
    if (prev_done && Grant != '0) begin
      nerr++; $display("FAIL idle_gap: got grant %b, required 0", Grant);
    end
    if (Done) begin
      if (sbq.size() == 0) begin
        nerr++; $display("FAIL unexpected_done: got done id %0d, required none", Done_id);
      end else begin
        e = sbq.pop_front();
        check("done_id", int'(Done_id), e.id);
        check("err", int'(Err), e.err);
        check("en_cycles", en_cnt, e.en);
        check("grant_cycles", gcnt, e.gc);
        check("grant_at_done", int'(Grant), 1 << e.id);
      end
    end
    prev_done = Done;
  end

  task automatic wait_done(input int n);
    int seen = 0;
    for (int cyc = 0; cyc < 300 && seen < n; cyc++) begin
      @(negedge clk);
      if (Done) seen++;
    end
    check("done_timeout", seen, n);
  endtask

  task automatic apply(input logic [1:0] req, input int l0, input int l1, input int id);
    @(negedge clk);
    #1;
    Req = req;
    Len = {LEN_W'(l1), LEN_W'(l0)};
    push_exp(id, (id == 0) ? l0 : l1);
    wait_done(1);
    #1;
    Req = '0;
  endtask

  vec_t vt[7];

  initial begin
    int ens;
    vt[0] = '{2'b01, 3, 0, 0};
    vt[1] = '{2'b10, 0, 9, 1};
    vt[2] = '{2'b01, 0, 0, 0};
    vt[3] = '{2'b11, 5, 2, 1};
    vt[4] = '{2'b11, 15, 1, 0};
    vt[5] = '{2'b10, 0, 8, 1};
    vt[6] = '{2'b01, 7, 0, 0};

    Reset = 1'b1; Req = '0; Len = '0;
    repeat (2) @(negedge clk);
    check("rst_grant", int'(Grant), 0);
    check("rst_busy", int'(Busy), 0);
    check("rst_done", int'(Done), 0);
    check("rst_done_id", int'(Done_id), 0);
    check("rst_err", int'(Err), 0);
    check("rst_gray_en", int'(Gray_En), 0);
    check("rst_gray_reset", int'(Gray_Reset), 1);
    #1 Reset = 1'b0;

    for (int i = 0; i < 7; i++) apply(vt[i].req, vt[i].len0, vt[i].len1, vt[i].id);

    // Both requesters held from reset: 0, 1, 0 in turn.
    @(negedge clk);
    #1;
    Reset = 1'b1; Req = 2'b11; Len = {LEN_W'(2), LEN_W'(2)};
    push_exp(0, 2); push_exp(1, 2); push_exp(0, 2);
    repeat (2) @(negedge clk);
    #1 Reset = 1'b0;
    wait_done(3);
    #1 Req = '0;

    // Req dropped and Len changed after the grant.
    @(negedge clk);
    #1;
    Req = 2'b01; Len = {LEN_W'(0), LEN_W'(4)};
    push_exp(0, 4);
    ens = 0;
    for (int c = 0; c < 20 && Grant == '0; c++) @(negedge clk);
    check("grant_seen", int'(Grant), 1);
    #1;
    Req = '0; Len = {LEN_W'(0), LEN_W'(1)};
    wait_done(1);

    // Reset on the 3rd RUN cycle, then re-arbitration starts from requester 0.
    apply(2'b01, 1, 0, 0);
    @(negedge clk);
    #1;
    Req = 2'b01; Len = {LEN_W'(0), LEN_W'(6)};
    ens = 0;
    for (int c = 0; c < 30 && ens < 3; c++) begin
      @(negedge clk);
      if (Gray_En) ens++;
    end
    check("run_en_before_reset", ens, 3);
    #1 Reset = 1'b1;
    @(negedge clk);
    check("abort_grant", int'(Grant), 0);
    check("abort_busy", int'(Busy), 0);
    check("abort_gray_en", int'(Gray_En), 0);
    check("abort_done", int'(Done), 0);
    #1;
    Reset = 1'b0; Req = 2'b11; Len = {LEN_W'(1), LEN_W'(1)};
    push_exp(0, 1); push_exp(1, 1);
    wait_done(2);
    #1 Req = '0;

    repeat (3) @(negedge clk);
    check("sb_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
